dtree_feature_sequencer: RTL

- Sequential front-end/back-end wrapper for the combinational arrhythmia decision-tree classifier.
- Accepts one patient record as a byte stream of all NUM_FEATURES 8-bit features in index order.
- Latches only the five features the tree consumes and drives them as stable parallel inputs to the tree.
- After a settle delay, samples the tree's 5-bit class and returns it on a valid/ready output channel, with record-length error flagging.

---
 rtl/dtree_feature_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dtree_feature_sequencer.sv
// Byte-stream front end for the arrhythmia decision tree: latches the five consumed features,
// waits for the tree to settle, then returns the class on a valid/ready channel.
module dtree_feature_sequencer #(
  parameter int unsigned NUM_FEATURES = 279,
  parameter int unsigned IDX0         = 13,
  parameter int unsigned IDX1         = 27,
  parameter int unsigned IDX2         = 235,
  parameter int unsigned IDX3         = 264,
  parameter int unsigned IDX4         = 278,
  parameter int unsigned SETTLE       = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic [7:0]       feat0,
  output logic [7:0]       feat1,
  output logic [7:0]       feat2,
  output logic [7:0]       feat3,
  output logic [7:0]       feat4,
  input  logic [4:0]       class_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [4:0]       m_class,
  output logic             m_error,
  output logic [CNT_W-1:0] rec_count
);

  localparam int unsigned IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [4:0][IDX_W-1:0] IDX_TAB = {IDX_W'(IDX4), IDX_W'(IDX3), IDX_W'(IDX2),
                                               IDX_W'(IDX1), IDX_W'(IDX0)};

  typedef enum logic [1:0] {StLoad, StDrain, StSettle, StHold} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SET_W-1:0]  cnt_q, cnt_d;
  logic [4:0][7:0]   feat_q, feat_d;
  logic              err_q, err_d;
  logic              m_valid_q, m_valid_d;
  logic [4:0]        m_class_q, m_class_d;
  logic              m_error_q, m_error_d;
  logic [CNT_W-1:0]  rec_count_q, rec_count_d;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      cnt_q       <= '0;
      feat_q      <= '0;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      m_error_q   <= 1'b0;
      rec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      feat_q      <= feat_d;
      err_q       <= err_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      m_error_q   <= m_error_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign s_ready = !rst && ((state_q == StLoad) || (state_q == StDrain));
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    feat_d      = feat_q;
    err_d       = err_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    m_error_d   = m_error_q;
    rec_count_d = rec_count_q;

    case (state_q)
      StLoad: begin
        if (xfer) begin
          for (int k = 0; k < 5; k++) begin
            if (idx_q == IDX_TAB[k]) feat_d[k] = s_data;
          end
          if (s_last) begin
            err_d   = (idx_q != LAST_IDX);
            cnt_d   = '0;
            state_d = StSettle;
          end else if (idx_q == LAST_IDX) begin
            // Record too long: flag it and swallow bytes until s_last.
            err_d   = 1'b1;
            state_d = StDrain;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (xfer && s_last) begin
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == SET_LAST) begin
          m_class_d = class_in;
          m_error_d = err_q;
          m_valid_d = 1'b1;
          state_d   = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          feat_d    = '0;
          err_d     = 1'b0;
          idx_d     = '0;
          if (rec_count_q != '1) rec_count_d = rec_count_q + 1'b1;
          state_d   = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign feat0     = feat_q[0];
  assign feat1     = feat_q[1];
  assign feat2     = feat_q[2];
  assign feat3     = feat_q[3];
  assign feat4     = feat_q[4];
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign m_error   = m_error_q;
  assign rec_count = rec_count_q;

endmodule
